// File: rtl/qdiv_seq_if.sv
// Handshake and operand/result bundle for the sequential Q-format divider.
interface qdiv_seq_if #(
  parameter int unsigned N = 32
);
  logic         i_start;
  logic [N-1:0] i_dividend;
  logic [N-1:0] i_divisor;
  logic [N-1:0] o_result;
  logic         o_busy;
  logic         o_complete;
  logic         o_ovr;
  logic         o_dbz;

  // Requester side: issues operands and start, observes result flags.
  modport master (
    output i_start, i_dividend, i_divisor,
    input  o_result, o_busy, o_complete, o_ovr, o_dbz
  );

  // Divider side.
  modport slave (
    input  i_start, i_dividend, i_divisor,
    output o_result, o_busy, o_complete, o_ovr, o_dbz
  );
endinterface

// File: rtl/qdiv_seq.sv
// Sequential sign-magnitude Q-format divider: restoring long division,
// one quotient bit per clock, start/complete handshake.
module qdiv_seq #(
  parameter int unsigned Q = 15,
  parameter int unsigned N = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  qdiv_seq_if.slave   bus
);

  localparam int unsigned W  = N - 1 + Q;
  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_rem;
  logic [W-1:0]   r_qn;
  logic [N-2:0]   r_div;
  logic           r_sign;
  logic           r_dbz;
  logic [N-1:0]   r_result;
  logic           r_busy;
  logic           r_complete;
  logic           r_ovr;
  logic           r_dbz_o;

  logic [N-1:0]   w_rem_sh;
  logic           w_ge;
  logic [N-1:0]   w_rem_nx;
  logic [W-1:0]   w_qn_nx;
  logic           w_qovf;

  // One restoring-division step. r_qn holds unconsumed numerator bits at the
  // top and accumulated quotient bits at the bottom; each step consumes the
  // MSB and appends a quotient bit, so after W steps it is the full quotient.
  always_comb begin
    w_rem_sh = {r_rem[N-2:0], r_qn[W-1]};
    w_ge     = (w_rem_sh >= {1'b0, r_div});
    w_rem_nx = w_ge ? (w_rem_sh - {1'b0, r_div}) : w_rem_sh;
    w_qn_nx  = {r_qn[W-2:0], w_ge};
    w_qovf   = |r_qn[W-1:N-1];
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_qn       <= '0;
      r_div      <= '0;
      r_sign     <= 1'b0;
      r_dbz      <= 1'b0;
      r_result   <= '0;
      r_busy     <= 1'b0;
      r_complete <= 1'b0;
      r_ovr      <= 1'b0;
      r_dbz_o    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_complete <= 1'b0;
          if (bus.i_start) begin
            r_div   <= bus.i_divisor[N-2:0];
            r_sign  <= bus.i_dividend[N-1] ^ bus.i_divisor[N-1];
            r_dbz   <= (bus.i_divisor[N-2:0] == '0);
            r_qn    <= W'(bus.i_dividend[N-2:0]) << Q;
            r_rem   <= '0;
            r_cnt   <= CW'(W);
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_rem <= w_rem_nx;
          r_qn  <= w_qn_nx;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_busy     <= 1'b0;
          r_complete <= 1'b1;
          r_dbz_o    <= r_dbz;
          if (r_dbz || w_qovf) begin
            r_result <= {r_sign, {(N-1){1'b1}}};
            r_ovr    <= 1'b1;
          end else begin
            r_result <= {r_sign, r_qn[N-2:0]};
            r_ovr    <= 1'b0;
          end
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Drive the interface from the registered outputs.
  always_comb begin
    bus.o_result   = r_result;
    bus.o_busy     = r_busy;
    bus.o_complete = r_complete;
    bus.o_ovr      = r_ovr;
    bus.o_dbz      = r_dbz_o;
  end

endmodule
